// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux output.
// Grants are held for at most BURST beats while the other side is waiting.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [1:0]       grant
);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_sel_q, out_sel_d;

    logic space;
    logic gnt_idx;
    logic gnt_valid;
    logic oth_valid;
    logic xfer;

    always_comb begin
        space     = !out_valid_q || out_ready;
        gnt_idx   = (state_q == G1);
        gnt_valid = gnt_idx ? in1_valid : in0_valid;
        oth_valid = gnt_idx ? in0_valid : in1_valid;
        xfer      = (state_q != IDLE) && gnt_valid && space;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // a tie goes to whichever side was not served last
                if (in0_valid && in1_valid) state_d = last_q ? G0 : G1;
                else if (in0_valid)         state_d = G0;
                else if (in1_valid)         state_d = G1;
            end
            G0, G1: begin
                if (!gnt_valid) begin
                    last_d  = gnt_idx;
                    cnt_d   = '0;
                    state_d = oth_valid ? (gnt_idx ? G0 : G1) : IDLE;
                end else if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (oth_valid) begin
                            last_d  = gnt_idx;
                            state_d = gnt_idx ? G0 : G1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_idx ? in1_data : in0_data;
            out_sel_d   = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign in0_ready = rst_n && (state_q == G0) && space;
    assign in1_ready = rst_n && (state_q == G1) && space;
    assign grant     = {state_q == G1, state_q == G0};
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: producers feed per-source queues,
// expected output order is pushed up front and popped as beats leave the DUT.
module tb_mux2_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0_valid = 1'b0;
    logic [7:0] in0_data = '0;
    logic       in0_ready;
    logic       in1_valid = 1'b0;
    logic [7:0] in1_data = '0;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       out_sel;
    logic [1:0] grant;

    mux2_rr_arbiter #(.WIDTH(8), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_sel(out_sel), .grant(grant)
    );

    always #5 clk = ~clk;

    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [8:0] exp_q[$];

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  n_taken = 0;
    int  last_take_cyc = 0;
    bit  first_take = 1'b1;
    bit  chk_gap = 1'b0;
    bit  en0 = 1'b1;
    bit  en1 = 1'b1;
    bit  rst_cfg = 1'b0;
    bit  rdy_cfg = 1'b1;
    bit  acc0 = 1'b0;
    bit  acc1 = 1'b0;

    // One clock: apply the handshakes of the edge, drive new inputs at posedge+1,
    // then sample at the negedge and score any beat the next edge will consume.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (acc0 && src0.size() > 0) void'(src0.pop_front());
        if (acc1 && src1.size() > 0) void'(src1.pop_front());
        rst_n     = rst_cfg;
        out_ready = rdy_cfg;
        in0_valid = en0 && (src0.size() > 0);
        in0_data  = (src0.size() > 0) ? src0[0] : 8'h00;
        in1_valid = en1 && (src1.size() > 0);
        in1_data  = (src1.size() > 0) ? src1[0] : 8'h00;
        @(negedge clk);
        acc0 = (in0_valid && in0_ready) === 1'b1;
        acc1 = (in1_valid && in1_ready) === 1'b1;
        if ((out_valid && out_ready) === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected beat sel=%0d data=%h, required none", out_sel, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    errors++;
                    $display("FAIL beat: got sel=%0d data=%h, required sel=%0d data=%h", out_sel, out_data, e[8], e[7:0]);
                end
            end
            if (chk_gap && !first_take) begin
                checks++;
                if (cyc != last_take_cyc + 1) begin
                    errors++;
                    $display("FAIL gap: beat after %0d cycles, required 1", cyc - last_take_cyc);
                end
            end
            first_take    = 1'b0;
            last_take_cyc = cyc;
            n_taken++;
        end
    endtask

    task automatic clear_all();
        src0.delete();
        src1.delete();
        exp_q.delete();
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        en0 = 1'b1;
        en1 = 1'b1;
        rdy_cfg = 1'b1;
        rst_cfg = 1'b0;
        tick();
        tick();
        rst_cfg = 1'b1;
        tick();
        first_take = 1'b1;
        chk_gap = 1'b0;
    endtask

    task automatic run_until_empty(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), n);
            clear_all();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_all();
        rst_cfg = 1'b0;
        src0.push_back(8'h01);
        src1.push_back(8'h02);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i >= 1) begin
                checks += 4;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
                if (grant !== 2'b00) begin errors++; $display("FAIL reset grant: got %b, required 00", grant); end
                if (in0_ready !== 1'b0) begin errors++; $display("FAIL reset in0_ready: got %b, required 0", in0_ready); end
                if (in1_ready !== 1'b0) begin errors++; $display("FAIL reset in1_ready: got %b, required 0", in1_ready); end
            end
        end
        clear_all();
        rst_cfg = 1'b1;
        tick();
    endtask

    task automatic test_single_source();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src0.push_back(8'h10 + 8'(i));
            exp_q.push_back({1'b0, 8'h10 + 8'(i)});
        end
        chk_gap = 1'b1;
        tick();
        checks += 2;
        if (grant !== 2'b00) begin errors++; $display("FAIL single bubble grant: got %b, required 00", grant); end
        if (in0_ready !== 1'b0) begin errors++; $display("FAIL single bubble in0_ready: got %b, required 0", in0_ready); end
        tick();
        checks += 2;
        if (grant !== 2'b01) begin errors++; $display("FAIL single grant: got %b, required 01", grant); end
        if (in0_ready !== 1'b1) begin errors++; $display("FAIL single in0_ready: got %b, required 1", in0_ready); end
        run_until_empty(40, "single");
        chk_gap = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 8; i++) src0.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) src1.push_back(8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'hB0 + 8'(i)});
        for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
        chk_gap = 1'b1;
        run_until_empty(60, "contention");
        chk_gap = 1'b0;
    endtask

    task automatic test_backpressure();
        int base;
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) src0.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) src1.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h20 + 8'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h30 + 8'(i)});
        base = n_taken;
        n = 0;
        while (n_taken - base < 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n_taken - base < 2) begin
            errors++;
            $display("FAIL backpressure start: %0d beats out, required 2", n_taken - base);
        end
        rdy_cfg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall out_valid: got %b, required 1", out_valid); end
            if (exp_q.size() > 0 && out_data !== exp_q[0][7:0]) begin errors++; $display("FAIL stall out_data: got %h, required %h", out_data, exp_q[0][7:0]); end
            if (in0_ready !== 1'b0) begin errors++; $display("FAIL stall in0_ready: got %b, required 0", in0_ready); end
            if (grant !== 2'b01) begin errors++; $display("FAIL stall grant: got %b, required 01", grant); end
        end
        rdy_cfg = 1'b1;
        run_until_empty(40, "backpressure");
    endtask

    task automatic test_early_release();
        int n;
        do_reset();
        src1.push_back(8'h50);
        src1.push_back(8'h51);
        src0.push_back(8'h40);
        src0.push_back(8'h41);
        exp_q.push_back({1'b1, 8'h50});
        exp_q.push_back({1'b1, 8'h51});
        exp_q.push_back({1'b0, 8'h40});
        exp_q.push_back({1'b0, 8'h41});
        en0 = 1'b0;
        tick();
        en0 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (in1_valid !== 1'b0 && n < 20);
        checks += 2;
        if (grant !== 2'b10) begin errors++; $display("FAIL release grant before: got %b, required 10", grant); end
        tick();
        if (grant !== 2'b01) begin errors++; $display("FAIL release grant after: got %b, required 01", grant); end
        run_until_empty(30, "release");
    endtask

    task automatic test_midburst_reset();
        int base;
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) src0.push_back(8'h60 + 8'(i));
        for (int i = 0; i < 4; i++) src1.push_back(8'h70 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h60 + 8'(i)});
        base = n_taken;
        n = 0;
        while (n_taken - base < 2 && n < 20) begin
            tick();
            n++;
        end
        rdy_cfg = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset held beat: out_valid=%b, required 1", out_valid); end
        rst_cfg = 1'b0;
        tick();
        checks += 2;
        if (in0_ready !== 1'b0) begin errors++; $display("FAIL midreset in0_ready: got %b, required 0", in0_ready); end
        if (in1_ready !== 1'b0) begin errors++; $display("FAIL midreset in1_ready: got %b, required 0", in1_ready); end
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b, required 0", out_valid); end
        if (grant !== 2'b00) begin errors++; $display("FAIL midreset grant: got %b, required 00", grant); end
        clear_all();
        rst_cfg = 1'b1;
        rdy_cfg = 1'b1;
        src0.push_back(8'h80);
        src0.push_back(8'h81);
        src1.push_back(8'h90);
        src1.push_back(8'h91);
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b1, 8'h90});
        exp_q.push_back({1'b1, 8'h91});
        run_until_empty(30, "midreset tie");
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_early_release();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
